// File: rtl/seg7_scan_decoder_if.sv
// Multiplexed 7-segment display bus as seen by the scan decoder.
// The master side drives segments and digit select and receives the decoded view.
interface seg7_scan_decoder_if #(
  parameter int NB_DIGITS = 4
);
  logic [0:6]             seg;
  logic [NB_DIGITS-1:0]   digSel;
  logic [4*NB_DIGITS-1:0] nbOut;
  logic [NB_DIGITS-1:0]   digValid;
  logic                   frameValid;
  logic                   errPattern;
  logic                   errSel;

  modport master (
    output seg, digSel,
    input  nbOut, digValid, frameValid, errPattern, errSel
  );

  modport slave (
    input  seg, digSel,
    output nbOut, digValid, frameValid, errPattern, errSel
  );
endinterface

// File: rtl/seg7_scan_decoder.sv
// Monitors a multiplexed 7-segment bus and rebuilds the hex value of every digit.
// A sample is accepted only after STABLE_CYCLES identical consecutive samples.
module seg7_scan_decoder #(
  parameter int NB_DIGITS       = 4,
  parameter bit INPUT_POLARITY  = 1'b1,
  parameter bit DIGSEL_POLARITY = 1'b1,
  parameter int STABLE_CYCLES   = 4
) (
  input logic                clk_i,
  input logic                reset_i,
  seg7_scan_decoder_if.slave disp_io
);

  localparam int CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STABLE_CYCLES);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [NB_DIGITS-1:0] SelOne = NB_DIGITS'(1);

  typedef enum logic {
    StWait,
    StHold
  } state_e;

  state_e                 stateQ, stateD;
  logic [CntW-1:0]        cntQ, cntD;
  logic [0:6]             segIn, segQ;
  logic [NB_DIGITS-1:0]   selIn, selQ;
  logic                   sampleSame;
  logic                   capture;
  logic                   multiSel;
  logic [4:0]             decoded;
  logic [4*NB_DIGITS-1:0] nbOutQ, nbOutD;
  logic [NB_DIGITS-1:0]   digValidQ, digValidD;
  logic [NB_DIGITS-1:0]   seenQ, seenD;
  logic                   frameValidQ, frameValidD;
  logic                   errPatternQ, errPatternD;
  logic                   errSelQ, errSelD;

  // Returns {hit, value}; the table matches the nibble encoder, bit order a..g.
  function automatic logic [4:0] decodeSeg(input logic [0:6] s);
    case (s)
      7'b1111110: return {1'b1, 4'h0};
      7'b0110000: return {1'b1, 4'h1};
      7'b1101101: return {1'b1, 4'h2};
      7'b1111001: return {1'b1, 4'h3};
      7'b0110011: return {1'b1, 4'h4};
      7'b1011011: return {1'b1, 4'h5};
      7'b1011111: return {1'b1, 4'h6};
      7'b1110000: return {1'b1, 4'h7};
      7'b1111111: return {1'b1, 4'h8};
      7'b1111011: return {1'b1, 4'h9};
      7'b1110111: return {1'b1, 4'hA};
      7'b0011111: return {1'b1, 4'hB};
      7'b1001110: return {1'b1, 4'hC};
      7'b0111101: return {1'b1, 4'hD};
      7'b1001111: return {1'b1, 4'hE};
      7'b1000111: return {1'b1, 4'hF};
      default:    return 5'b0_0000;
    endcase
  endfunction

  assign segIn      = INPUT_POLARITY  ? disp_io.seg    : ~disp_io.seg;
  assign selIn      = DIGSEL_POLARITY ? disp_io.digSel : ~disp_io.digSel;
  assign sampleSame = (segIn == segQ) && (selIn == selQ);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stateQ <= StWait;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // cntQ counts how many consecutive edges have sampled the value now held in segQ/selQ.
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    unique case (stateQ)
      StWait: begin
        if (!sampleSame) begin
          cntD = CntOne;
        end else if (cntQ == CntMax) begin
          stateD = StHold;
        end else begin
          cntD = cntQ + CntOne;
        end
      end
      StHold: begin
        if (!sampleSame) begin
          stateD = StWait;
          cntD   = CntOne;
        end
      end
      default: begin
        stateD = StWait;
        cntD   = CntOne;
      end
    endcase
  end

  assign capture = (stateQ == StWait) && (cntQ == CntMax);

  assign multiSel = (selQ & (selQ - SelOne)) != '0;
  assign decoded  = decodeSeg(segQ);

  always_comb begin
    nbOutD      = nbOutQ;
    digValidD   = digValidQ;
    seenD       = seenQ;
    frameValidD = 1'b0;
    errPatternD = 1'b0;
    errSelD     = 1'b0;
    if (capture) begin
      if (multiSel) begin
        errSelD = 1'b1;
      end else if (selQ != '0) begin
        for (int k = 0; k < NB_DIGITS; k++) begin
          if (selQ[k]) begin
            if (decoded[4]) begin
              nbOutD[4*k +: 4] = decoded[3:0];
              digValidD[k]     = 1'b1;
            end else begin
              digValidD[k] = 1'b0;
              errPatternD  = (segQ != 7'b0000000);
            end
          end
        end
        // A bad or blank pattern still counts toward the frame.
        seenD = seenQ | selQ;
        if (&seenD) begin
          frameValidD = 1'b1;
          seenD       = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      segQ        <= '0;
      selQ        <= '0;
      nbOutQ      <= '0;
      digValidQ   <= '0;
      seenQ       <= '0;
      frameValidQ <= 1'b0;
      errPatternQ <= 1'b0;
      errSelQ     <= 1'b0;
    end else begin
      segQ        <= segIn;
      selQ        <= selIn;
      nbOutQ      <= nbOutD;
      digValidQ   <= digValidD;
      seenQ       <= seenD;
      frameValidQ <= frameValidD;
      errPatternQ <= errPatternD;
      errSelQ     <= errSelD;
    end
  end

  assign disp_io.nbOut      = nbOutQ;
  assign disp_io.digValid   = digValidQ;
  assign disp_io.frameValid = frameValidQ;
  assign disp_io.errPattern = errPatternQ;
  assign disp_io.errSel     = errSelQ;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: debounce, scan/frame, errors, polarity, reset.
// dutA uses default polarities, dutB inverts both segment and select lines.
module tb_seg7_scan_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int compared = 0;
  int mismatched = 0;

  seg7_scan_decoder_if #(.NB_DIGITS(4)) ifA ();
  seg7_scan_decoder_if #(.NB_DIGITS(4)) ifB ();

  seg7_scan_decoder #(
    .NB_DIGITS(4), .INPUT_POLARITY(1'b1), .DIGSEL_POLARITY(1'b1), .STABLE_CYCLES(4)
  ) dutA (
    .clk_i(clk), .reset_i(reset), .disp_io(ifA.slave)
  );

  seg7_scan_decoder #(
    .NB_DIGITS(4), .INPUT_POLARITY(1'b0), .DIGSEL_POLARITY(1'b0), .STABLE_CYCLES(4)
  ) dutB (
    .clk_i(clk), .reset_i(reset), .disp_io(ifB.slave)
  );

  always #5 clk = ~clk;

  task automatic setA(input logic [0:6] s, input logic [3:0] d);
    @(negedge clk);
    ifA.seg    = s;
    ifA.digSel = d;
  endtask

  task automatic stepEdges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Runs n cycles on dutA, counting pulse cycles and the index of the last pulse.
  task automatic runA(input int n, output int frames, output int frameAt,
                      output int errPats, output int errPatAt, output int errSels);
    frames = 0; frameAt = -1; errPats = 0; errPatAt = -1; errSels = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (ifA.frameValid === 1'b1) begin frames++; frameAt = i; end
      if (ifA.errPattern === 1'b1) begin errPats++; errPatAt = i; end
      if (ifA.errSel === 1'b1) errSels++;
    end
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset = 1'b1;
    ifA.seg = 7'b0000000; ifA.digSel = 4'b0000;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifA.seg = 7'b0000000; ifA.digSel = 4'b0000;
    ifB.seg = 7'b1111111; ifB.digSel = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    compared++;
    if (ifA.nbOut !== 16'h0000) begin
      mismatched++; $display("[TB] FAIL reset_nbOut: got %h want 0000", ifA.nbOut);
    end
    compared++;
    if (ifA.digValid !== 4'b0000) begin
      mismatched++; $display("[TB] FAIL reset_digValid: got %b want 0000", ifA.digValid);
    end
    compared++;
    if ({ifA.frameValid, ifA.errPattern, ifA.errSel} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL reset_pulses: got %b want 000", {ifA.frameValid, ifA.errPattern, ifA.errSel});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_stable_capture();
    setA(7'b1111110, 4'b0001);
    stepEdges(4);
    compared++;
    if (ifA.digValid !== 4'b0000) begin
      mismatched++; $display("[TB] FAIL early_capture: digValid got %b want 0000", ifA.digValid);
    end
    stepEdges(1);
    compared++;
    if (ifA.digValid !== 4'b0001) begin
      mismatched++; $display("[TB] FAIL capture_edge4: digValid got %b want 0001", ifA.digValid);
    end
    compared++;
    if (ifA.nbOut[3:0] !== 4'h0) begin
      mismatched++; $display("[TB] FAIL capture_value: got %h want 0", ifA.nbOut[3:0]);
    end
    setA(7'b0110000, 4'b0010);
    stepEdges(3);
    setA(7'b0000000, 4'b0000);
    stepEdges(6);
    compared++;
    if (ifA.digValid !== 4'b0001 || ifA.nbOut !== 16'h0000) begin
      mismatched++;
      $display("[TB] FAIL short_hold: got %b/%h want 0001/0000", ifA.digValid, ifA.nbOut);
    end
  endtask

  task automatic test_scan_frame();
    logic [0:6] pats [0:3];
    int fr, frAt, ep, epAt, es;
    int frameTotal = 0, frameTag = -1, errTotal = 0;
    pats[3] = 7'b1110111; pats[2] = 7'b0011111;
    pats[1] = 7'b1001110; pats[0] = 7'b0111101;
    pulseReset();
    for (int d = 3; d >= 0; d--) begin
      setA(pats[d], 4'(1 << d));
      runA(6, fr, frAt, ep, epAt, es);
      frameTotal += fr;
      errTotal += ep + es;
      if (fr > 0) frameTag = d * 10 + frAt;
    end
    compared++;
    if (ifA.nbOut !== 16'hABCD) begin
      mismatched++; $display("[TB] FAIL scan_nbOut: got %h want ABCD", ifA.nbOut);
    end
    compared++;
    if (ifA.digValid !== 4'b1111) begin
      mismatched++; $display("[TB] FAIL scan_digValid: got %b want 1111", ifA.digValid);
    end
    compared++;
    if (frameTotal !== 1 || frameTag !== 4) begin
      mismatched++;
      $display("[TB] FAIL scan_frame: count %0d tag %0d want 1 tag 4", frameTotal, frameTag);
    end
    compared++;
    if (errTotal !== 0) begin
      mismatched++; $display("[TB] FAIL scan_errors: got %0d want 0", errTotal);
    end
  endtask

  task automatic test_bad_pattern();
    int fr, frAt, ep, epAt, es;
    setA(7'b1000000, 4'b0100);
    runA(6, fr, frAt, ep, epAt, es);
    compared++;
    if (ep !== 1 || epAt !== 4) begin
      mismatched++; $display("[TB] FAIL bad_pattern_pulse: count %0d at %0d want 1 at 4", ep, epAt);
    end
    compared++;
    if (fr !== 0 || es !== 0) begin
      mismatched++; $display("[TB] FAIL bad_pattern_other: frame %0d errSel %0d want 0 0", fr, es);
    end
    compared++;
    if (ifA.digValid !== 4'b1011 || ifA.nbOut !== 16'hABCD) begin
      mismatched++;
      $display("[TB] FAIL bad_pattern_state: got %b/%h want 1011/ABCD", ifA.digValid, ifA.nbOut);
    end
  endtask

  task automatic test_bad_select();
    int fr, frAt, ep, epAt, es;
    setA(7'b1111110, 4'b0011);
    runA(6, fr, frAt, ep, epAt, es);
    compared++;
    if (es !== 1 || ep !== 0 || fr !== 0) begin
      mismatched++;
      $display("[TB] FAIL multi_sel_pulses: errSel %0d errPat %0d frame %0d want 1 0 0", es, ep, fr);
    end
    compared++;
    if (ifA.digValid !== 4'b1011 || ifA.nbOut !== 16'hABCD) begin
      mismatched++;
      $display("[TB] FAIL multi_sel_state: got %b/%h want 1011/ABCD", ifA.digValid, ifA.nbOut);
    end
    setA(7'b1111110, 4'b0000);
    runA(6, fr, frAt, ep, epAt, es);
    compared++;
    if (es + ep + fr !== 0) begin
      mismatched++; $display("[TB] FAIL blanking_pulses: got %0d want 0", es + ep + fr);
    end
    compared++;
    if (ifA.digValid !== 4'b1011 || ifA.nbOut !== 16'hABCD) begin
      mismatched++;
      $display("[TB] FAIL blanking_state: got %b/%h want 1011/ABCD", ifA.digValid, ifA.nbOut);
    end
  endtask

  task automatic test_polarity();
    int errs = 0;
    @(negedge clk);
    ifB.seg = 7'b0000110;
    ifB.digSel = 4'b1110;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (ifB.errPattern === 1'b1 || ifB.errSel === 1'b1) errs++;
    end
    compared++;
    if (ifB.nbOut[3:0] !== 4'h3) begin
      mismatched++; $display("[TB] FAIL polarity_value: got %h want 3", ifB.nbOut[3:0]);
    end
    compared++;
    if (ifB.digValid !== 4'b0001 || errs !== 0) begin
      mismatched++;
      $display("[TB] FAIL polarity_valid: got %b errs %0d want 0001 errs 0", ifB.digValid, errs);
    end
  endtask

  task automatic test_reset_midframe();
    int fr, frAt, ep, epAt, es;
    int frameTotal = 0;
    setA(7'b0110000, 4'b0001);
    runA(6, fr, frAt, ep, epAt, es);
    frameTotal += fr;
    setA(7'b1101101, 4'b0010);
    runA(6, fr, frAt, ep, epAt, es);
    frameTotal += fr;
    compared++;
    if (ifA.nbOut !== 16'hAB21 || ifA.digValid !== 4'b1011 || frameTotal !== 0) begin
      mismatched++;
      $display("[TB] FAIL pre_reset: got %h/%b frames %0d want AB21/1011 frames 0",
               ifA.nbOut, ifA.digValid, frameTotal);
    end
    @(negedge clk);
    reset = 1'b1;
    ifA.seg = 7'b0000000; ifA.digSel = 4'b0000;
    stepEdges(1);
    compared++;
    if (ifA.nbOut !== 16'h0000 || ifA.digValid !== 4'b0000 ||
        {ifA.frameValid, ifA.errPattern, ifA.errSel} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL mid_reset: got %h/%b want 0000/0000", ifA.nbOut, ifA.digValid);
    end
    @(negedge clk);
    reset = 1'b0;
    frameTotal = 0;
    setA(7'b1011011, 4'b0100);
    runA(6, fr, frAt, ep, epAt, es);
    frameTotal += fr;
    setA(7'b1110000, 4'b1000);
    runA(6, fr, frAt, ep, epAt, es);
    frameTotal += fr;
    setA(7'b1111111, 4'b0001);
    runA(6, fr, frAt, ep, epAt, es);
    frameTotal += fr;
    compared++;
    if (frameTotal !== 0) begin
      mismatched++; $display("[TB] FAIL stale_seen: frames %0d want 0", frameTotal);
    end
    setA(7'b1001111, 4'b0010);
    runA(6, fr, frAt, ep, epAt, es);
    compared++;
    if (fr !== 1 || frAt !== 4) begin
      mismatched++; $display("[TB] FAIL new_frame: count %0d at %0d want 1 at 4", fr, frAt);
    end
    compared++;
    if (ifA.nbOut !== 16'h75E8 || ifA.digValid !== 4'b1111) begin
      mismatched++;
      $display("[TB] FAIL new_frame_state: got %h/%b want 75E8/1111", ifA.nbOut, ifA.digValid);
    end
  endtask

  initial begin
    test_reset();
    test_stable_capture();
    test_scan_frame();
    test_bad_pattern();
    test_bad_select();
    test_polarity();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
